mmio_uart_tx: RTL

- Memory-mapped UART transmitter slave on the data-memory map, alongside RAM and the UART receiver.
- Responds to bus writes and reads from the core's memory-map master.
- Buffers bytes in a small FIFO and serialises them onto tx as 8N1 frames, LSB first, using a programmable baud divider.

---
 rtl/mmio_uart_tx_pkg.sv | 37 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 48 ++++
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - register map, STATUS bit positions and FSM state type for mmio_uart_tx
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } tx_state_t;
`endif

  // STATUS count field is 4 bits wide; deeper FIFOs report 15 when fuller
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - sync_fifo: synchronous-reset FIFO with full/empty/count, guarded push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; MMIO_UART_TX_PARITY_EN adds a parity bit
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int DEFAULT_BAUD_DIV = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   r_state;
  logic [15:0] r_baud;
  logic        r_enable;
  logic        r_overflow;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_period;
  logic        r_tx;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        r_parity_en;
  logic        r_odd;
  logic        r_frame_par_en;
  logic        r_par_bit;
`endif

  logic [1:0]    w_sel;
  logic          w_wr_tx;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifo_dout;
  logic          w_cnt_done;
  logic          w_start;
  logic [15:0]   w_period;
  logic [31:0]   w_rd32;
  logic          w_unused_bits;

  assign w_sel         = address[3:2];
  assign w_wr_tx       = we && (w_sel == REG_TXDATA);
  assign w_cnt_done    = (r_cnt == 16'd0);
  assign w_period      = (r_baud == 16'd0) ? 16'd1 : r_baud;
  // STOP's last cycle hands straight to the next START so frames abut
  assign w_start       = r_enable && !w_empty &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_cnt_done));
  assign w_unused_bits = ^{address[31:4], address[1:0], wd[DATA_WIDTH-1:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_wr_tx),
    .din  (wd[7:0]),
    .pop  (w_start),
    .dout (w_fifo_dout),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud     <= 16'(DEFAULT_BAUD_DIV);
      r_enable   <= 1'b1;
      r_overflow <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      r_parity_en <= 1'b0;
      r_odd       <= 1'b0;
`endif
    end else begin
      if (we && (w_sel == REG_BAUD)) r_baud <= wd[15:0];
      if (we && (w_sel == REG_CTRL)) begin
        r_enable <= wd[0];
`ifdef MMIO_UART_TX_PARITY_EN
        r_parity_en <= wd[1];
        r_odd       <= wd[2];
`endif
      end
      if (w_wr_tx && w_full)
        r_overflow <= 1'b1;
      else if (we && (w_sel == REG_STATUS) && wd[ST_OVF])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_cnt     <= 16'd0;
      r_period  <= 16'd1;
`ifdef MMIO_UART_TX_PARITY_EN
      r_frame_par_en <= 1'b0;
      r_par_bit      <= 1'b0;
`endif
    end else if (w_start) begin
      r_state   <= START;
      r_tx      <= 1'b0;
      r_shift   <= w_fifo_dout;
      r_bit_idx <= 3'd0;
      r_period  <= w_period;
      r_cnt     <= w_period - 16'd1;
`ifdef MMIO_UART_TX_PARITY_EN
      r_frame_par_en <= r_parity_en;
      r_par_bit      <= (^w_fifo_dout) ^ r_odd;
`endif
    end else if (r_state != IDLE) begin
      if (!w_cnt_done) begin
        r_cnt <= r_cnt - 16'd1;
      end else begin
        r_cnt <= r_period - 16'd1;
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
          DATA: begin
            if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              if (r_frame_par_en) begin
                r_state <= PARITY;
                r_tx    <= r_par_bit;
              end else
`endif
              begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
`ifdef MMIO_UART_TX_PARITY_EN
          PARITY: begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
`endif
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rd32 = 32'd0;
    if (re) begin
      case (w_sel)
        REG_STATUS: begin
          w_rd32[ST_FULL]           = w_full;
          w_rd32[ST_EMPTY]          = w_empty;
          w_rd32[ST_BUSY]           = tx_busy;
          w_rd32[ST_OVF]            = r_overflow;
          w_rd32[ST_CNT_LSB +: 4]   = sat_count(32'(w_count));
        end
        REG_BAUD: w_rd32[15:0] = r_baud;
        REG_CTRL: begin
          w_rd32[0] = r_enable;
`ifdef MMIO_UART_TX_PARITY_EN
          w_rd32[1] = r_parity_en;
          w_rd32[2] = r_odd;
`endif
        end
        default: w_rd32 = 32'd0;
      endcase
    end
  end

  assign rd      = DATA_WIDTH'(w_rd32);
  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE) | ~w_empty;

endmodule
